// File: rtl/iter_div_unit.sv
// Radix-2 restoring divider for the EX stage: DIV/DIVU/REM/REMU and W variants.
// Divide-by-zero and signed overflow bypass the iteration and finish in one cycle.
module iter_div_unit #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_start,
  input  logic            div_signed,
  input  logic            div_32,
  input  logic            div_res_sel,
  input  logic [XLEN-1:0] div_data1,
  input  logic [XLEN-1:0] div_data2,
  input  logic            cancel,
  output logic [XLEN-1:0] div_result,
  output logic            div_over,
  output logic            div_busy
);

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_END} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   dividend_q, divisor_q, rem_q, quot_q, special_q, result_q;
  logic [CW-1:0]     count_q;
  logic              negQ_q, negR_q, is32_q, resSel_q, isSpecial_q, over_q;

  logic [XLEN-1:0]   op1Ext, op2Ext, op1Zext, op2Zext, mag1, mag2;
  logic              sign1, sign2, divZero, overflow;
  logic [XLEN-1:0]   specialRes, dividendLoad;
  logic [XLEN:0]     remShift;
  logic              stepBit;
  logic [XLEN-1:0]   stepRem, quotSigned, remSigned, selRes, finalRes;
  logic [CW-1:0]     lastCount;

  // W operands: sign-extended view for signed math, zero-extended view for unsigned
  always_comb begin
    op1Ext   = div_32 ? {{HALF{div_data1[HALF-1]}}, div_data1[HALF-1:0]} : div_data1;
    op2Ext   = div_32 ? {{HALF{div_data2[HALF-1]}}, div_data2[HALF-1:0]} : div_data2;
    op1Zext  = div_32 ? {{HALF{1'b0}}, div_data1[HALF-1:0]} : div_data1;
    op2Zext  = div_32 ? {{HALF{1'b0}}, div_data2[HALF-1:0]} : div_data2;
    sign1    = div_signed & op1Ext[XLEN-1];
    sign2    = div_signed & op2Ext[XLEN-1];
    mag1     = sign1 ? -op1Ext : op1Zext;
    mag2     = sign2 ? -op2Ext : op2Zext;
    divZero  = (op2Zext == '0);
    overflow = div_signed && (op2Ext == '1) &&
               (div_32 ? (div_data1[HALF-1:0] == {1'b1, {(HALF-1){1'b0}}})
                       : (div_data1 == {1'b1, {(XLEN-1){1'b0}}}));
    if (divZero)
      specialRes = div_res_sel ? '1 : op1Ext;
    else
      specialRes = div_res_sel ? op1Ext : '0;
    // W dividends are left-aligned so the iteration always consumes bit XLEN-1 first
    dividendLoad = div_32 ? {mag1[HALF-1:0], {HALF{1'b0}}} : mag1;
  end

  always_comb begin
    remShift   = {rem_q, dividend_q[XLEN-1]};
    stepBit    = (remShift >= {1'b0, divisor_q});
    stepRem    = stepBit ? (remShift[XLEN-1:0] - divisor_q) : remShift[XLEN-1:0];
    lastCount  = is32_q ? CW'(HALF - 1) : CW'(XLEN - 1);
    quotSigned = negQ_q ? -quot_q : quot_q;
    remSigned  = negR_q ? -rem_q : rem_q;
    if (isSpecial_q)
      selRes = special_q;
    else
      selRes = resSel_q ? quotSigned : remSigned;
    finalRes   = is32_q ? {{HALF{selRes[HALF-1]}}, selRes[HALF-1:0]} : selRes;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (div_start && !cancel) state_d = (divZero || overflow) ? S_END : S_BUSY;
      S_BUSY: if (cancel) state_d = S_IDLE;
              else if (count_q == lastCount) state_d = S_END;
      S_END:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    div_busy   = (state_q != S_IDLE);
    div_over   = over_q;
    div_result = result_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dividend_q  <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quot_q      <= '0;
      special_q   <= '0;
      result_q    <= '0;
      count_q     <= '0;
      negQ_q      <= 1'b0;
      negR_q      <= 1'b0;
      is32_q      <= 1'b0;
      resSel_q    <= 1'b0;
      isSpecial_q <= 1'b0;
      over_q      <= 1'b0;
    end else begin
      over_q <= (state_q == S_END) && !cancel;
      case (state_q)
        S_IDLE: if (div_start && !cancel) begin
          dividend_q  <= dividendLoad;
          divisor_q   <= mag2;
          rem_q       <= '0;
          quot_q      <= '0;
          count_q     <= '0;
          negQ_q      <= sign1 ^ sign2;
          negR_q      <= sign1;
          is32_q      <= div_32;
          resSel_q    <= div_res_sel;
          isSpecial_q <= divZero || overflow;
          special_q   <= specialRes;
        end
        S_BUSY: if (!cancel) begin
          dividend_q <= {dividend_q[XLEN-2:0], 1'b0};
          rem_q      <= stepRem;
          quot_q     <= {quot_q[XLEN-2:0], stepBit};
          count_q    <= count_q + 1'b1;
        end
        S_END: if (!cancel) result_q <= finalRes;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_div_unit.sv
// Self-checking bench for iter_div_unit: directed test-plan steps followed by
// randomized operations checked against an arithmetic reference model.
module tb_iter_div_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        div_start = 1'b0;
  logic        div_signed = 1'b0;
  logic        div_32 = 1'b0;
  logic        div_res_sel = 1'b0;
  logic [63:0] div_data1 = '0;
  logic [63:0] div_data2 = '0;
  logic        cancel = 1'b0;
  logic [63:0] div_result;
  logic        div_over;
  logic        div_busy;

  int checks = 0;
  int failures = 0;

  iter_div_unit #(.XLEN(64)) dut (
    .clk(clk), .rst(rst), .div_start(div_start), .div_signed(div_signed),
    .div_32(div_32), .div_res_sel(div_res_sel), .div_data1(div_data1),
    .div_data2(div_data2), .cancel(cancel), .div_result(div_result),
    .div_over(div_over), .div_busy(div_busy)
  );

  always #5 clk = ~clk;

  // RISC-V division semantics computed directly with language arithmetic
  function automatic logic [63:0] refModel(input logic [63:0] d1, input logic [63:0] d2,
                                           input logic sgn, input logic w, input logic sel);
    logic [63:0] q, r;
    logic [31:0] a32, b32, q32, r32;
    int          sa, sb;
    longint      la, lb;
    if (w) begin
      a32 = d1[31:0];
      b32 = d2[31:0];
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32;
      end else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0;
      end else if (sgn) begin
        sa = a32; sb = b32;
        q32 = sa / sb; r32 = sa % sb;
      end else begin
        q32 = a32 / b32; r32 = a32 % b32;
      end
      q = {{32{q32[31]}}, q32};
      r = {{32{r32[31]}}, r32};
    end else begin
      if (d2 == 64'd0) begin
        q = '1; r = d1;
      end else if (sgn && d1 == 64'h8000_0000_0000_0000 && d2 == '1) begin
        q = d1; r = '0;
      end else if (sgn) begin
        la = d1; lb = d2;
        q = la / lb; r = la % lb;
      end else begin
        q = d1 / d2; r = d1 % d2;
      end
    end
    return sel ? q : r;
  endfunction

  function automatic int refLatency(input logic [63:0] d1, input logic [63:0] d2,
                                    input logic sgn, input logic w);
    logic special;
    if (w) special = (d2[31:0] == 32'd0) ||
                     (sgn && d1[31:0] == 32'h8000_0000 && d2[31:0] == 32'hFFFF_FFFF);
    else   special = (d2 == 64'd0) ||
                     (sgn && d1 == 64'h8000_0000_0000_0000 && d2 == '1);
    return special ? 1 : (w ? 33 : 65);
  endfunction

  task automatic checkEq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one request; returns just after the start-sampling edge
  task automatic applyStimulus(input logic [63:0] d1, input logic [63:0] d2,
                               input logic sgn, input logic w, input logic sel);
    @(negedge clk);
    div_data1 = d1; div_data2 = d2; div_signed = sgn; div_32 = w; div_res_sel = sel;
    div_start = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0;
    div_data1 = {$urandom, $urandom};
    div_data2 = {$urandom, $urandom};
  endtask

  // Waits (bounded) for div_over and checks latency, result and one-cycle pulse width
  task automatic checkOutput(input string tag, input logic [63:0] expRes, input int expLat);
    int lat = -1;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk);
      #1;
      if (div_over) begin
        lat = k;
        break;
      end
    end
    checkEq({tag, "_lat"}, 64'(lat), 64'(expLat));
    checkEq({tag, "_res"}, div_result, expRes);
    @(posedge clk);
    #1;
    checkEq({tag, "_pulse"}, {63'd0, div_over}, 64'd0);
  endtask

  task automatic runOp(input string tag, input logic [63:0] d1, input logic [63:0] d2,
                       input logic sgn, input logic w, input logic sel,
                       input logic [63:0] expRes, input int expLat);
    applyStimulus(d1, d2, sgn, w, sel);
    checkOutput(tag, expRes, expLat);
  endtask

  initial begin
    logic [63:0] prior, rd1, rd2;
    logic        rs, rw, rsel;
    int          overs;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkEq("reset_result", div_result, 64'd0);
    checkEq("reset_over", {63'd0, div_over}, 64'd0);
    checkEq("reset_busy", {63'd0, div_busy}, 64'd0);
    rst = 1'b0;

    runOp("u64_q", 64'd100, 64'd7, 1'b0, 1'b0, 1'b1, 64'd14, 65);
    runOp("u64_r", 64'd100, 64'd7, 1'b0, 1'b0, 1'b0, 64'd2, 65);
    runOp("s_q_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    runOp("s_r_m7_2", -64'sd7, 64'd2, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    runOp("s_q_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    runOp("s_r_7_m2", 64'd7, -64'sd2, 1'b1, 1'b0, 1'b0, 64'd1, 65);
    runOp("dz_u_q", 64'h1234, 64'd0, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    runOp("dz_u_r", 64'h1234, 64'd0, 1'b0, 1'b0, 1'b0, 64'h1234, 1);
    runOp("dz_s_q", 64'h1234, 64'd0, 1'b1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    runOp("dz_s_r", 64'h1234, 64'd0, 1'b1, 1'b0, 1'b0, 64'h1234, 1);
    runOp("ovf64_q", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b1, 64'h8000_0000_0000_0000, 1);
    runOp("ovf64_r", 64'h8000_0000_0000_0000, '1, 1'b1, 1'b0, 1'b0, 64'd0, 1);
    runOp("ovfW_q", 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0000, 1);
    runOp("wu_q", 64'h0000_0000_FFFF_FFFE, 64'd1, 1'b0, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    runOp("wu_junk_q", 64'hDEAD_BEEF_FFFF_FFFE, 64'hA5A5_A5A5_0000_0001, 1'b0, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 33);
    runOp("wdz_q", 64'hFFFF_0000_0000_0005, 64'hFFFF_FFFF_0000_0000, 1'b0, 1'b1, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFF, 1);

    // cancel in IDLE outranks a simultaneous start
    @(negedge clk);
    div_data1 = 64'd50; div_data2 = 64'd5; div_start = 1'b1; cancel = 1'b1;
    @(posedge clk);
    #1;
    div_start = 1'b0; cancel = 1'b0;
    checkEq("idle_cancel_busy", {63'd0, div_busy}, 64'd0);

    // cancel during BUSY
    prior = div_result;
    applyStimulus(64'd1000, 64'd3, 1'b0, 1'b0, 1'b1);
    checkEq("busy_after_start", {63'd0, div_busy}, 64'd1);
    repeat (9) @(posedge clk);
    @(negedge clk);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    checkEq("cancel_busy", {63'd0, div_busy}, 64'd0);
    overs = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (div_over) overs++;
    end
    checkEq("cancel_no_over", 64'(overs), 64'd0);
    checkEq("cancel_keep_result", div_result, prior);
    runOp("after_cancel_q", 64'd1000, 64'd3, 1'b0, 1'b0, 1'b1, 64'd333, 65);

    // reset mid-BUSY
    applyStimulus(64'd999, 64'd4, 1'b0, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkEq("rst_mid_result", div_result, 64'd0);
    checkEq("rst_mid_over", {63'd0, div_over}, 64'd0);
    checkEq("rst_mid_busy", {63'd0, div_busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // start held through the whole operation yields exactly one result
    @(negedge clk);
    div_data1 = 64'd77; div_data2 = 64'd10; div_signed = 1'b0; div_32 = 1'b1;
    div_res_sel = 1'b0; div_start = 1'b1;
    overs = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge clk);
      #1;
      if (div_over) begin
        overs++;
        div_start = 1'b0;
        checkEq("held_start_res", div_result, 64'd7);
      end
    end
    div_start = 1'b0;
    checkEq("held_start_overs", 64'(overs), 64'd1);
    checkEq("held_start_idle", {63'd0, div_busy}, 64'd0);

    for (int i = 0; i < 24; i++) begin
      rs = 1'($urandom); rw = 1'($urandom); rsel = 1'($urandom);
      rd1 = {$urandom, $urandom};
      rd2 = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: rd2 = rw ? {rd2[63:32], 32'd0} : 64'd0;
        1: begin
          rs = 1'b1;
          rd1 = rw ? {rd1[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          rd2 = rw ? {rd2[63:32], 32'hFFFF_FFFF} : '1;
        end
        2: rd2 = {{56{rd2[7]}}, rd2[7:0]};
        default: ;
      endcase
      runOp($sformatf("rand%0d", i), rd1, rd2, rs, rw, rsel,
            refModel(rd1, rd2, rs, rw, rsel), refLatency(rd1, rd2, rs, rw));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
